// File: rtl/fmig_pkg.sv
// Shared types and helpers for the row min-sum sequencer.
//   fmig_state_e : sequencer states
//   max_mag()    : largest positive magnitude for a given message width
//   gidx()       : global edge index from (chunk, lane)
package fmig_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PASS1,
        S_PASS2,
        S_DONE
    } fmig_state_e;

    function automatic int max_mag(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    function automatic int gidx(input int chunk, input int lane, input int k);
        return (chunk << k) + lane;
    endfunction

endpackage

// File: rtl/fmig_row_sched_fmig2k.sv
// FMIG2k: combinational minimum finder over L = 2^K signed lanes.
//   in_data : L lanes of BITS each, lane j at in_data[j*BITS +: BITS]
//   m       : smallest lane value (signed)
//   lane    : lane holding m; on ties the lowest lane wins
module FMIG2k #(
    parameter int BITS = 8,
    parameter int K    = 4,
    localparam int L   = 1 << K,
    localparam int LW  = (K > 0) ? K : 1
) (
    input  logic [L*BITS-1:0]      in_data,
    output logic signed [BITS-1:0] m,
    output logic [LW-1:0]          lane
);

    logic signed [BITS-1:0] cand;

    always_comb begin
        m    = $signed(in_data[BITS-1:0]);
        lane = '0;
        cand = '0;
        for (int j = 1; j < L; j++) begin
            cand = $signed(in_data[j*BITS +: BITS]);
            // Strict compare keeps the lower lane on equal values.
            if (cand < m) begin
                m    = cand;
                lane = LW'(j);
            end
        end
    end

endmodule

// File: rtl/fmig_row_sched.sv
// fmig_row_sched: buffers one parity-check row of DEG = CHUNKS*2^K messages
// and runs one FMIG2k across it twice: pass 1 finds min1/idx1, pass 2 finds
// min2 with edge idx1 forced to MAX_MAG.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input beat handshake, in_data = one chunk of L lanes
//   out_valid/out_ready : result handshake; min1, min2, idx1 held while valid
//   busy                : sequencer is not idle
module fmig_row_sched
    import fmig_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int K      = 4,
    parameter int CHUNKS = 4,
    localparam int L     = 1 << K,
    localparam int DEG   = L * CHUNKS,
    localparam int IDXW  = (DEG > 1) ? $clog2(DEG) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [L*BITS-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [BITS-1:0] min1,
    output logic signed [BITS-1:0] min2,
    output logic [IDXW-1:0]        idx1,
    output logic                   busy
);

    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int LW = (K > 0) ? K : 1;
    localparam logic [CW-1:0]          LAST = CW'(CHUNKS - 1);
    localparam logic signed [BITS-1:0] MAXV = BITS'(max_mag(BITS));

    fmig_state_e state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic [L*BITS-1:0]      row_buf [CHUNKS];
    logic [L*BITS-1:0]      chunk_data;
    logic signed [BITS-1:0] fm_min;
    logic [LW-1:0]          fm_lane;
    logic signed [BITS-1:0] run_min, cand_min;
    logic [IDXW-1:0]        run_idx, cand_idx;
    logic                   accept, take, last;

    // Chunk select plus pass-2 masking of the winning edge.
    always_comb begin
        chunk_data = row_buf[cnt];
        if (state == S_PASS2) begin
            for (int j = 0; j < L; j++) begin
                if ((int'(cnt) == (int'(idx1) >> K)) && (j == (int'(idx1) & (L - 1))))
                    chunk_data[j*BITS +: BITS] = MAXV;
            end
        end
    end

    FMIG2k #(.BITS(BITS), .K(K)) u_fmig (
        .in_data (chunk_data),
        .m       (fm_min),
        .lane    (fm_lane)
    );

    // First chunk seeds the running minimum; later chunks replace it only when
    // strictly smaller, so the earliest chunk wins ties.
    assign take     = (cnt == '0) || (fm_min < run_min);
    assign cand_min = take ? fm_min : run_min;
    assign cand_idx = take ? IDXW'(gidx(int'(cnt), int'(fm_lane), K)) : run_idx;
    assign last     = (cnt == LAST);
    assign accept   = in_valid & in_ready;
    assign busy     = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        in_ready  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (CHUNKS == 1) begin
                        state_nxt = S_PASS1;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = S_LOAD;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (last) begin
                        state_nxt = S_PASS1;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            S_PASS1: begin
                if (last) begin
                    state_nxt = S_PASS2;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_PASS2: begin
                if (last) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            min1      <= '0;
            min2      <= '0;
            idx1      <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == S_PASS1 && last) begin
                min1 <= cand_min;
                idx1 <= cand_idx;
            end
            if (state == S_PASS2 && last) begin
                min2      <= cand_min;
                out_valid <= 1'b1;
            end else if (state == S_DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Row buffer and running min/idx carry no reset; they are always
    // rewritten before being used.
    always_ff @(posedge clk) begin
        if (accept) row_buf[cnt] <= in_data;
        if (state == S_PASS1 || state == S_PASS2) begin
            run_min <= cand_min;
            run_idx <= cand_idx;
        end
    end

endmodule

// File: tb/tb_fmig_row_sched.sv
module tb_fmig_row_sched;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic signed [7:0] min1, min2;
    logic [2:0]        idx1;
    logic              busy;

    int n_assert = 0;
    int n_fail   = 0;
    int lat;

    always #5 clk = ~clk;

    fmig_row_sched #(.BITS(8), .K(2), .CHUNKS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .min1      (min1),
        .min2      (min2),
        .idx1      (idx1),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Lane 0 is the first argument.
    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic send_beat(input string tag, input logic [31:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
    endtask

    task automatic check_res(input string tag, input int e1, input int ei, input int e2);
        check({tag, "_min1"}, 32'(min1), 32'(e1));
        check({tag, "_idx1"}, 32'(idx1), 32'(ei));
        check({tag, "_min2"}, 32'(min2), 32'(e2));
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_hs_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_hs_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check_res("rst", 0, 0, 0);

        // Basic row
        send_beat("r1b0", pk(9, 3, 7, 5));
        check("r1_load_busy", 32'(busy), 32'd1);
        send_beat("r1b1", pk(6, 3, 2, 8));
        check("r1_pass_in_ready", 32'(in_ready), 32'd0);
        wait_out("r1");
        check_res("r1", 2, 6, 3);
        handshake("r1");

        // All values equal
        send_beat("r2b0", pk(5, 5, 5, 5));
        send_beat("r2b1", pk(5, 5, 5, 5));
        wait_out("r2");
        check_res("r2", 5, 0, 5);
        handshake("r2");

        // Duplicate minimum across chunks
        send_beat("r3b0", pk(4, 9, 9, 9));
        send_beat("r3b1", pk(4, 9, 9, 9));
        wait_out("r3");
        check_res("r3", 4, 0, 4);
        handshake("r3");

        // Mask saturation, then backpressure in DONE
        send_beat("r4b0", pk(127, 127, 127, 127));
        send_beat("r4b1", pk(127, 0, 127, 127));
        wait_out("r4");
        check_res("r4", 0, 5, 127);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold", {19'd0, out_valid, in_ready, min1, min2, idx1},
                  {19'd0, 1'b1, 1'b0, 8'd0, 8'd127, 3'd5});
        end
        handshake("r4");
        check("r4_hs_in_ready", 32'(in_ready), 32'd1);

        // Next row accepted on the cycle after the handshake; reset mid-PASS1
        send_beat("r5b0", pk(20, 21, 22, 23));
        send_beat("r5b1", pk(24, 25, 26, 27));
        @(posedge clk);
        #2;
        check("r5_pass1_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_res("mid_rst", 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh row after reset
        send_beat("r6b0", pk(1, 2, 3, 4));
        send_beat("r6b1", pk(5, 6, 7, 8));
        wait_out("r6");
        check_res("r6", 1, 0, 2);
        handshake("r6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
